// File: rtl/flags_pkg.sv
// Shared types and result-selection helper for the pipelined compare-flags unit.
package flags_pkg;

    typedef enum logic [2:0] {
        OP_EQ    = 3'd0,
        OP_NE    = 3'd1,
        OP_LT    = 3'd2,
        OP_GE    = 3'd3,
        OP_LTU   = 3'd4,
        OP_GEU   = 3'd5,
        OP_ZERO  = 3'd6,
        OP_NZERO = 3'd7
    } cmp_op_t;

    function automatic logic sel_result(
        input logic    zero,
        input logic    equal,
        input logic    lt,
        input logic    ltu,
        input cmp_op_t op
    );
        logic r;
        case (op)
            OP_EQ:    r = equal;
            OP_NE:    r = ~equal;
            OP_LT:    r = lt;
            OP_GE:    r = ~lt;
            OP_LTU:   r = ltu;
            OP_GEU:   r = ~ltu;
            OP_ZERO:  r = zero;
            OP_NZERO: r = ~zero;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/group_or_reduce.sv
// First-stage reduction: OR of each GROUP-bit slice, so the wide zero test
// finishes in stage 2 as a short NOR instead of one deep OR tree.
module group_or_reduce #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8
) (
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH/GROUP-1:0] o_or
);

    for (genvar g = 0; g < WIDTH / GROUP; g++) begin : g_grp
        assign o_or[g] = |i_data[g*GROUP +: GROUP];
    end

endmodule

// File: rtl/cmp_flags_pipe.sv
// Two-stage compare unit with valid/ready handshake, raw zero/equal/lt/ltu
// flags, and a sticky hit flag plus saturating hit counter on consumed results.
module cmp_flags_pipe
    import flags_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  cmp_op_t          in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic             out_zero,
    output logic             out_equal,
    output logic             out_lt,
    output logic             out_ltu,
    input  logic             clear,
    output logic             sticky_hit,
    output logic [CNT_W-1:0] hit_count
);

    localparam int NG = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0) begin : g_width_check
        $error("cmp_flags_pipe: WIDTH must be a multiple of GROUP");
    end

    logic [NG-1:0]  w_gor_a;
    logic [NG-1:0]  w_gor_x;
    logic [WIDTH:0] w_diff;
    logic           w_s1_load;
    logic           w_s2_load;
    logic           w_zero;
    logic           w_equal;
    logic           w_lt;
    logic           w_ltu;
    logic           w_consume;

    logic           r_s1_valid;
    cmp_op_t        r_s1_op;
    logic [NG-1:0]  r_s1_gor_a;
    logic [NG-1:0]  r_s1_gor_x;
    logic [WIDTH:0] r_s1_diff;
    logic           r_s1_a_msb;
    logic           r_s1_b_msb;

    group_or_reduce #(.WIDTH(WIDTH), .GROUP(GROUP)) u_or_a (
        .i_data (in_a),
        .o_or   (w_gor_a)
    );

    group_or_reduce #(.WIDTH(WIDTH), .GROUP(GROUP)) u_or_x (
        .i_data (in_a ^ in_b),
        .o_or   (w_gor_x)
    );

    // Borrow out of the zero-extended subtract is the unsigned less-than.
    assign w_diff    = {1'b0, in_a} - {1'b0, in_b};

    assign w_s2_load = ~out_valid | out_ready;
    assign w_s1_load = ~r_s1_valid | w_s2_load;
    assign in_ready  = rst_n & w_s1_load;

    assign w_zero    = ~|r_s1_gor_a;
    assign w_equal   = ~|r_s1_gor_x;
    assign w_ltu     = r_s1_diff[WIDTH];
    // Differing signs decide signed order directly; otherwise A-B cannot overflow.
    assign w_lt      = (r_s1_a_msb != r_s1_b_msb) ? r_s1_a_msb : r_s1_diff[WIDTH-1];
    assign w_consume = out_valid & out_ready & out_result;

    // Stage 1: capture operand reductions on an accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_EQ;
            r_s1_gor_a <= '0;
            r_s1_gor_x <= '0;
            r_s1_diff  <= '0;
            r_s1_a_msb <= 1'b0;
            r_s1_b_msb <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op    <= in_op;
                r_s1_gor_a <= w_gor_a;
                r_s1_gor_x <= w_gor_x;
                r_s1_diff  <= w_diff;
                r_s1_a_msb <= in_a[WIDTH-1];
                r_s1_b_msb <= in_b[WIDTH-1];
            end
        end
    end

    // Stage 2: finish the flags and register the selected result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= 1'b0;
            out_zero   <= 1'b0;
            out_equal  <= 1'b0;
            out_lt     <= 1'b0;
            out_ltu    <= 1'b0;
        end else if (w_s2_load) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_result <= sel_result(w_zero, w_equal, w_lt, w_ltu, r_s1_op);
                out_zero   <= w_zero;
                out_equal  <= w_equal;
                out_lt     <= w_lt;
                out_ltu    <= w_ltu;
            end
        end
    end

    // Hit status: clear has priority, counter saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_hit <= 1'b0;
            hit_count  <= '0;
        end else if (clear) begin
            sticky_hit <= 1'b0;
            hit_count  <= '0;
        end else if (w_consume) begin
            sticky_hit <= 1'b1;
            if (hit_count != {CNT_W{1'b1}}) begin
                hit_count <= hit_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_cmp_flags_pipe.sv
// Self-checking bench: directed scenarios plus a random phase, scored against
// a queue-based reference model computed from plain signed/unsigned compares.
module tb_cmp_flags_pipe;
    import flags_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready4;
    logic [31:0] in_a;
    logic [31:0] in_b;
    cmp_op_t     in_op;
    logic        out_ready;
    logic        clear;
    logic        out_valid, out_result, out_zero, out_equal, out_lt, out_ltu;
    logic        out_valid4, out_result4, out_zero4, out_equal4, out_lt4, out_ltu4;
    logic        sticky_hit, sticky_hit4;
    logic [15:0] hit_count;
    logic [3:0]  hit_count4;

    cmp_flags_pipe #(.WIDTH(32), .GROUP(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
        .out_equal(out_equal), .out_lt(out_lt), .out_ltu(out_ltu),
        .clear(clear), .sticky_hit(sticky_hit), .hit_count(hit_count)
    );

    cmp_flags_pipe #(.WIDTH(32), .GROUP(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid4),
        .out_ready(out_ready), .out_result(out_result4), .out_zero(out_zero4),
        .out_equal(out_equal4), .out_lt(out_lt4), .out_ltu(out_ltu4),
        .clear(clear), .sticky_hit(sticky_hit4), .hit_count(hit_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic res;
        logic zero;
        logic eq;
        logic lt;
        logic ltu;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt16 = 0;
    int   m_cnt4 = 0;
    logic m_sticky = 1'b0;
    logic last_hs_in;
    logic last_hs_out;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input cmp_op_t op);
        exp_t e;
        e.zero = (a == 32'd0);
        e.eq   = (a == b);
        e.lt   = ($signed(a) < $signed(b));
        e.ltu  = (a < b);
        case (op)
            OP_EQ:    e.res = e.eq;
            OP_NE:    e.res = !e.eq;
            OP_LT:    e.res = e.lt;
            OP_GE:    e.res = !e.lt;
            OP_LTU:   e.res = e.ltu;
            OP_GEU:   e.res = !e.ltu;
            OP_ZERO:  e.res = e.zero;
            default:  e.res = !e.zero;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: scores handshakes just before the posedge, then
    // checks status registers after it, and returns at the next negedge.
    task automatic tick();
        exp_t e;
        logic cons;
        #4;
        last_hs_in  = in_valid & in_ready;
        last_hs_out = out_valid & out_ready;
        cons = 1'b0;
        if (last_hs_in) exp_q.push_back(model(in_a, in_b, in_op));
        if (last_hs_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_result", {63'd0, out_result}, {63'd0, e.res});
                chk("out_flags", {59'd0, out_zero, out_equal, out_lt, out_ltu},
                    {59'd0, e.zero, e.eq, e.lt, e.ltu});
                cons = e.res;
            end
        end
        if (clear) begin
            m_cnt16 = 0; m_cnt4 = 0; m_sticky = 1'b0;
        end else if (cons) begin
            m_sticky = 1'b1;
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        @(posedge clk);
        #1;
        chk("sticky_hit", {63'd0, sticky_hit}, {63'd0, m_sticky});
        chk("hit_count", {48'd0, hit_count}, m_cnt16);
        chk("hit_count4", {60'd0, hit_count4}, m_cnt4);
        @(negedge clk);
    endtask

    initial begin
        int n_ov;
        int acc;
        logic [4:0] snap;
        rst_n = 1'b0; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0;
        in_op = OP_EQ; out_ready = 1'b0; clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out", {58'd0, out_valid, out_result, out_zero, out_equal, out_lt, out_ltu}, 64'd0);
        chk("reset_status", {47'd0, sticky_hit, hit_count}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b1;

        // EQ latency
        in_valid = 1'b1; in_a = 32'h12345678; in_b = 32'h12345678; in_op = OP_EQ; out_ready = 1'b1;
        tick();
        chk("first_accept", {63'd0, last_hs_in}, 64'd1);
        in_valid = 1'b0;
        chk("lat_cycle1", {63'd0, out_valid}, 64'd0);
        tick();
        chk("lat_cycle2", {60'd0, out_valid, out_result, out_equal, out_zero}, 64'hE);
        tick();
        chk("eq_hit", {47'd0, sticky_hit, hit_count}, {47'd0, 1'b1, 16'd1});

        // LT / LTU / GEU on sign-boundary operands
        in_valid = 1'b1; in_a = 32'h80000000; in_b = 32'h7FFFFFFF;
        in_op = OP_LT;  tick();
        in_op = OP_LTU; tick();
        chk("lt_flags", {62'd0, out_lt, out_ltu}, 64'd2);
        in_op = OP_GEU; tick();
        in_valid = 1'b0;
        repeat (3) tick();

        // Single-bit sweep, NE, back-to-back
        clear = 1'b1; tick(); clear = 1'b0;
        n_ov = 0;
        for (int i = 0; i < 34; i++) begin
            in_valid = (i < 32);
            in_a = 32'hDEADBEEF; in_b = 32'hDEADBEEF ^ (32'd1 << (i % 32)); in_op = OP_NE;
            tick();
            if (last_hs_out) n_ov++;
        end
        in_valid = 1'b0;
        chk("sweep_outputs", n_ov, 64'd32);
        chk("sweep_hits", {48'd0, hit_count}, 64'd32);

        // Backpressure: fill both stages, stall, then drain
        out_ready = 1'b0; acc = 0;
        for (int i = 0; i < 8 && acc < 2; i++) begin
            in_valid = 1'b1; in_a = $urandom; in_b = (i == 0) ? in_a : $urandom;
            in_op = cmp_op_t'($urandom_range(0, 7));
            tick();
            if (last_hs_in) acc++;
        end
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        snap = {out_valid, out_result, out_equal, out_lt, out_ltu};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_stable", {59'd0, out_valid, out_result, out_equal, out_lt, out_ltu}, {59'd0, snap});
        end
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (last_hs_in || !in_valid) begin
                in_valid = (acc < 4); in_a = $urandom; in_b = $urandom;
                in_op = cmp_op_t'($urandom_range(0, 7));
            end
            tick();
            if (last_hs_in) acc++;
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, 64'd4);
        chk("bp_drained", exp_q.size(), 64'd0);

        // Saturation on CNT_W=4, then clear colliding with a consume
        clear = 1'b1; tick(); clear = 1'b0;
        in_a = 32'd0; in_b = 32'd5; in_op = OP_ZERO;
        in_valid = 1'b1; repeat (20) tick();
        in_valid = 1'b0; repeat (2) tick();
        chk("sat_cnt4", {60'd0, hit_count4}, 64'd15);
        chk("sat_cnt16", {48'd0, hit_count}, 64'd20);
        in_valid = 1'b1; tick(); in_valid = 1'b0; tick();
        chk("clr_pending", {63'd0, out_valid & out_result}, 64'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_wins", {58'd0, sticky_hit, sticky_hit4, hit_count4}, 64'd0);

        // Random phase
        for (int i = 0; i < 60; i++) begin
            if (last_hs_in || !in_valid) begin
                in_valid = $urandom_range(0, 3) != 0;
                in_a = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
                in_b = ($urandom_range(0, 3) == 0) ? in_a : $urandom;
                in_op = cmp_op_t'($urandom_range(0, 7));
            end
            out_ready = $urandom_range(0, 3) != 0;
            clear = $urandom_range(0, 15) == 0;
            tick();
        end
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rand_drained", exp_q.size(), 64'd0);

        // Asynchronous reset with both stages full
        out_ready = 1'b0; in_valid = 1'b1; in_a = 32'd0; in_op = OP_ZERO;
        repeat (3) tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_in_ready", {63'd0, in_ready}, 64'd0);
        exp_q.delete(); m_cnt16 = 0; m_cnt4 = 0; m_sticky = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_stale", {62'd0, out_valid, in_ready}, 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cmp_flags_pipe.md
Name: cmp_flags_pipe

Overview:
Parametrised, pipelined successor to the combinational check_zero32/check_equal32 flag units. Accepts operand pairs over a valid/ready handshake and evaluates one of eight compare ops. Returns the selected result plus the raw zero/equal/less flags two cycles later. Keeps a sticky hit flag and a saturating hit counter for the branch/compare path and debug visibility.

Parameters:
WIDTH, 32, operand width in bits; legal range 8..64; must be a multiple of GROUP.
GROUP, 8, bits per first-stage reduction group; legal values 4, 8, 16.
CNT_W, 16, width of the saturating hit counter.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand pair and op are valid.
in_ready  out  1  block can accept this cycle.
in_a  in  WIDTH  operand A.
in_b  in  WIDTH  operand B.
in_op  in  3  cmp_op_t compare select.
out_valid  out  1  result registers hold a valid result.
out_ready  in  1  consumer accepts the result.
out_result  out  1  selected compare result.
out_zero  out  1  A == 0.
out_equal  out  1  A == B.
out_lt  out  1  A < B, signed.
out_ltu  out  1  A < B, unsigned.
clear  in  1  synchronous clear of sticky_hit and hit_count.
sticky_hit  out  1  set by any consumed result equal to 1.
hit_count  out  CNT_W  number of consumed results equal to 1; saturates.

Behaviour:
- Reset (asynchronous, rst_n=0): every output register and all pipeline state go to 0.
  - Results: out_valid=0, out_result=0, out_zero=0, out_equal=0, out_lt=0, out_ltu=0.
  - Status: sticky_hit=0, hit_count=0.
  - Pipeline: s1_valid=0; all data registers 0.
  - Reset asserted mid-operation discards in-flight results. No partial output is produced after release.
- in_ready is low while rst_n=0. First acceptance is possible on the first clk edge after rst_n rises.
- Stage 1 (captures on in_valid & in_ready):
  - Registers op.
  - Registers per-group OR of A: WIDTH/GROUP bits.
  - Registers per-group OR of A^B: WIDTH/GROUP bits.
  - Registers {1'b0,A} - {1'b0,B} as WIDTH+1 bits.
  - Registers A[MSB] and B[MSB].
- Stage 2 (output registers):
  - zero = ~|groupOR_A.
  - equal = ~|groupOR_AxorB.
  - ltu = diff[WIDTH], the borrow.
  - lt = (A[MSB] != B[MSB]) ? A[MSB] : diff[WIDTH-1].
- out_result by op:
  - EQ = equal; NE = ~equal.
  - LT = lt; GE = ~lt.
  - LTU = ltu; GEU = ~ltu.
  - ZERO = zero; NZERO = ~zero.
- Latency: exactly 2 cycles from the input handshake to out_valid when not stalled. Throughput is 1 per cycle.
- Flow control:
  - s2_load = ~out_valid | out_ready.
  - s1_load = ~s1_valid | s2_load.
  - in_ready = s1_load. This is a combinational path from out_ready, and that path is intended.
- Stall: with out_valid=1 and out_ready=0, all outputs hold stable. Stage 1 holds its data once full. in_ready drops only when both stages are full.
- No bubbles are inserted: back-to-back inputs with out_ready held high give back-to-back outputs.
- Consume event = out_valid & out_ready & out_result.
- Consume event effects: sticky_hit <= 1; hit_count increments. At all-ones, hit_count stays all-ones (no wrap).
- clear=1 forces sticky_hit=0 and hit_count=0 next cycle. clear wins over a simultaneous consume event. The pipeline is unaffected by clear.
- sticky_hit and hit_count are registered and update the cycle after the event.

Decomposition:
- flags_pkg holds:
  - typedef enum logic [2:0] cmp_op_t with OP_EQ=0, OP_NE=1, OP_LT=2, OP_GE=3, OP_LTU=4, OP_GEU=5, OP_ZERO=6, OP_NZERO=7.
  - A function for result selection from {zero, equal, lt, ltu, op}.
- One sub-module, group_or_reduce:
  - Parametrised by WIDTH and GROUP; outputs a WIDTH/GROUP-bit vector of group ORs.
  - Instantiated twice: on A, and on A^B.
- Elaboration-time assertion rejects WIDTH % GROUP != 0.

Test Plan:
- Reset, then EQ A=0x12345678 B=0x12345678 with out_ready=1 -> out_valid on cycle +2; out_result=1, out_equal=1, out_zero=0; sticky_hit=1 and hit_count=1 the next cycle.
- LT A=0x80000000 B=0x7FFFFFFF -> out_lt=1, out_ltu=0, out_result=1. LTU on the same operands -> out_result=0. GEU on the same operands -> out_result=1.
- Single-bit sweep: A=0xDEADBEEF, B=A^(1<<i) for i=0..31, op=NE, streamed back-to-back -> 32 consecutive out_valid cycles, all results 1, hit_count=32.
- Backpressure: 4 inputs with out_ready=0 -> in_ready low after 2 accepted. Outputs hold stable over a 5-cycle stall. Releasing out_ready delivers all 4 in order with no loss or duplicate.
- Saturation and clear: CNT_W=4, 20 ZERO ops on A=0 -> hit_count=15 and holds. clear asserted in the same cycle as a consume -> hit_count=0, sticky_hit=0.
- Reset mid-flight: rst_n low while both stages are valid -> out_valid=0 immediately (asynchronous). After release, no stale result emerges and in_ready returns high.
